// File: rtl/rol_iter.sv
// rol_iter: iterative 16-bit rotate-left, one shift-amount bit per cycle (1/2/4/8 stages).
// Latency: 5 cycles from the start edge to done. With ROL_EARLY_DONE_EN it is 1 + (amt==0 ? 0 : h+1), where h is the highest set amount bit.
// Backpressure: none. start is ignored while busy, and the controller stalls on busy/done.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset, which overrides start in every state
//   start      request strobe, accepted in IDLE or DONE
//   Shift_In   16-bit operand, captured with start
//   Shift_Val  4-bit rotate-left amount, captured with start
//   busy       high while stages are being applied
//   done       one-cycle pulse; Shift_Out is valid during that cycle
//   Shift_Out  registered result, held until the next done
// Optional feature macro: ROL_EARLY_DONE_EN (stop after the highest set amount bit).
module rol_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] Shift_In,
  input  logic [3:0]  Shift_Val,
  output logic        busy,
  output logic        done,
  output logic [15:0] Shift_Out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] acc_q;
  logic [3:0]  amt_q;
  logic [1:0]  idx_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] out_q;

  logic [15:0] acc_d;
  logic        last_stage;
  logic        zero_fast;

  // Rotate by 2^i positions.
  function automatic logic [15:0] rotl_stage(input logic [15:0] x, input logic [1:0] i);
    logic [15:0] r;
    case (i)
      2'd0:    r = {x[14:0], x[15]};
      2'd1:    r = {x[13:0], x[15:14]};
      2'd2:    r = {x[11:0], x[15:12]};
      default: r = {x[7:0],  x[15:8]};
    endcase
    return r;
  endfunction

  // Apply the current stage only when its amount bit is set.
  assign acc_d = amt_q[idx_q] ? rotl_stage(acc_q, idx_q) : acc_q;

`ifdef ROL_EARLY_DONE_EN
  logic [1:0] hi_idx;
  // Find the index of the highest set amount bit. RUN is only entered with a non-zero amount.
  always_comb begin
    hi_idx = 2'd0;
    if (amt_q[3])      hi_idx = 2'd3;
    else if (amt_q[2]) hi_idx = 2'd2;
    else if (amt_q[1]) hi_idx = 2'd1;
  end
  assign last_stage = (idx_q == hi_idx);
  // A zero amount skips RUN and goes straight to DONE with the operand unchanged.
  assign zero_fast  = (Shift_Val == 4'd0);
`else
  assign last_stage = (idx_q == 2'd3);
  assign zero_fast  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= 16'h0000;
      amt_q   <= 4'd0;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= 16'h0000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts a new request just like IDLE, so back-to-back requests have no dead cycle.
        S_IDLE, S_DONE: begin
          if (start) begin
            acc_q <= Shift_In;
            amt_q <= Shift_Val;
            idx_q <= 2'd0;
            if (zero_fast) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              out_q   <= Shift_In;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 2'd1;
          if (last_stage) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= acc_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Shift_Out = out_q;

endmodule

// File: doc/rol_iter.md
# rol_iter

Iterative 16-bit rotate-left unit for the CPU datapath: the inverse direction of the datapath's combinational rotate-right. A registered request is processed one shift-amount bit per cycle: a 1-, 2-, 4- or 8-position stage is applied only when the matching amount bit is set. A start/busy/done handshake lets the controller stall on it, and the result is held in a register until the next request.

## Interface
- No parameters. Data width is fixed at 16 and amount width at 4.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset; synchronous and active-low.
- start  input  1  request strobe; sampled only when state is IDLE or DONE.
- Shift_In  input  16  operand; sampled on the edge that accepts start.
- Shift_Val  input  4  rotate-left amount, 0–15; sampled with Shift_In.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse: result valid on Shift_Out.
- Shift_Out  output  16  registered result; holds value until the next done.

## Operation
- Internal state:
  - acc[15:0]: working value.
  - amt[3:0]: latched amount.
  - idx[1:0]: stage counter.
  - FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start, load acc=Shift_In, amt=Shift_Val, idx=0, and go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If amt[idx], acc = rotl(acc, 2^idx).
  - idx increments.
  - When idx==3, go to DONE and load Shift_Out with the final rotated value in the same edge.
- DONE, lasts exactly one cycle (done=1):
  - If start is high here, the new request is accepted exactly as from IDLE and the FSM goes to RUN. This gives back-to-back operation with no dead cycle.
  - Otherwise go to IDLE.
- rotl(x,k) = {x[15-k:0], x[15:16-k]}. Every bit is preserved, so the population count of Shift_Out equals that of Shift_In.
- start is ignored while in RUN. No queuing; Shift_In and Shift_Val are don't-care in RUN.
- Amount 0 (macro absent): passes through all four stages unchanged, and Shift_Out = Shift_In.

## Timing
- Reset values (rst_n low at a rising edge): state=IDLE, busy=0, done=0, Shift_Out=16'h0000, acc=0, amt=0, idx=0.
- Reset has priority over start in every state.
- Latency, macro absent: fixed.
  - Request accepted at edge E0.
  - Stages are applied at E1..E4.
  - done=1 and Shift_Out valid in the cycle after E4.
  - busy=1 from after E0 through E4.
- Throughput: one result per 5 cycles, or every 5 cycles back-to-back with start held in DONE.
- Reset mid-RUN: the operation is aborted, no done is produced, and Shift_Out returns to 0.
- done never lasts more than one cycle. Shift_Out changes only on the edge that enters DONE, or on reset.

## Configuration
- ROL_EARLY_DONE_EN defined: early termination.
  - Let h be the index of the highest set bit of the latched amount.
  - RUN leaves after the stage with idx==h, so the request finishes after h+1 RUN cycles.
  - If Shift_Val==0 at acceptance, the FSM goes directly to DONE with Shift_Out=Shift_In. done is then high in the cycle after E0, and busy never asserts.
  - Latency = 1 + (Shift_Val==0 ? 0 : h+1) cycles from acceptance to done.
- ROL_EARLY_DONE_EN undefined: fixed 4-stage RUN for every amount, as specified above.
- Results are bit-identical in both configurations; only latency and busy duration differ.

## Test plan
- Shift_In=16'hA5C3, Shift_Val=4, start for one cycle:
  - busy is high 4 cycles.
  - done pulses in the 5th cycle after start, with Shift_Out=16'h5C3A.
- 16'h8001 by 1 gives 16'h0003.
- 16'h1234 by 15 gives 16'h091A.
- 16'hFFFF by 7 gives 16'hFFFF.
- 16'h0001 by each amount 0–15 gives 16'h0001<<n.
  - Macro defined: done latency must be 1, 2, 3, 3, 4, 4, 4, 4, 5, 5, … cycles, matching the formula.
- Pulse start again 2 cycles after acceptance with different data:
  - The request is ignored, and the first result appears unchanged.
- Hold start high in DONE with 16'h00F0 by 8:
  - The second done arrives 5 cycles later with Shift_Out=16'hF000.
- Assert rst_n=0 for one cycle during RUN:
  - Next cycle: state IDLE, busy=0, Shift_Out=0, and no done follows.
  - A fresh request afterwards completes correctly.
